// File: rtl/display_source_sched.sv
// Video source sequencer: picks which generator drives the colour mux,
// switches only at frame boundaries with black frames in between, and
// optionally cycles through the game sources on its own (attract mode).
module display_source_sched #(
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned BLANK_FRAMES = 4,
    parameter int unsigned AUTO_FRAMES  = 600,
    parameter int unsigned AUTO_LAST    = 3
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic [10:0] row,
    input  logic [2:0]  mode_req,
    input  logic        auto_en,
    output logic [2:0]  sel,
    output logic        force_black,
    output logic [7:0]  run_en,
    output logic        frame_tick,
    output logic        busy
);

    localparam logic [0:0]  ST_BLANK   = 1'b0;
    localparam logic [0:0]  ST_RUN     = 1'b1;

    localparam logic [10:0] ROW_BND    = 11'(V_ACTIVE);
    localparam logic [3:0]  BLANK_INIT = 4'(BLANK_FRAMES);
    localparam logic [11:0] AUTO_TOP   = 12'(AUTO_FRAMES - 1);
    localparam logic [2:0]  LAST_SRC   = 3'(AUTO_LAST);

    logic [0:0]  state_q, state_d;
    logic [10:0] row_q;
    logic        bnd;
    logic [2:0]  sel_d;
    logic [2:0]  pend_q, pend_d;
    logic [2:0]  req_q, req_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [11:0] auto_q, auto_d;
    logic        req_stable;
    logic [2:0]  auto_next;
    logic        force_black_d;
    logic        busy_d;
    logic [7:0]  run_en_d;

    // Boundary is the first cycle the row counter sits on V_ACTIVE, so a
    // row that lingers there yields a single tick.
    assign bnd        = (row == ROW_BND) && (row_q != ROW_BND);
    // Request is trusted only once it matches the value seen at the previous tick.
    assign req_stable = (mode_req == req_q);
    // Any source above the attract range (entered manually) wraps back to 0.
    assign auto_next  = (sel >= LAST_SRC) ? 3'd0 : sel + 3'd1;

    // Next-state logic; all sequencing decisions are taken on frame_tick.
    always_comb begin
        state_d = state_q;
        sel_d   = sel;
        pend_d  = pend_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        auto_d  = auto_q;

        if (frame_tick) begin
            req_d = mode_req;
            case (state_q)
                ST_RUN: begin
                    if (!auto_en) begin
                        if (req_stable && (mode_req != sel)) begin
                            state_d = ST_BLANK;
                            pend_d  = mode_req;
                            cnt_d   = BLANK_INIT;
                        end
                    end else if (auto_q == AUTO_TOP) begin
                        state_d = ST_BLANK;
                        pend_d  = auto_next;
                        cnt_d   = BLANK_INIT;
                    end else begin
                        auto_d = auto_q + 12'd1;
                    end
                end
                default: begin
                    // A fresh manual target during blanking restarts the black period.
                    if (!auto_en && req_stable && (mode_req != pend_q)) begin
                        pend_d = mode_req;
                        cnt_d  = BLANK_INIT;
                    end else if (cnt_q == 4'd1) begin
                        state_d = ST_RUN;
                        sel_d   = pend_q;
                        auto_d  = '0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            endcase
        end

        if (!auto_en) begin
            auto_d = '0;
        end
    end

    // Output decode from the next state so outputs stay aligned with state_q.
    always_comb begin
        force_black_d = (state_d != ST_RUN);
        busy_d        = (state_d != ST_RUN);
        run_en_d      = (state_d == ST_RUN) ? (8'h01 << sel_d) : 8'h00;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q     <= ST_BLANK;
            row_q       <= '0;
            frame_tick  <= 1'b0;
            sel         <= '0;
            pend_q      <= '0;
            req_q       <= '0;
            cnt_q       <= BLANK_INIT;
            auto_q      <= '0;
            force_black <= 1'b1;
            run_en      <= '0;
            busy        <= 1'b1;
        end else begin
            state_q     <= state_d;
            row_q       <= row;
            frame_tick  <= bnd;
            sel         <= sel_d;
            pend_q      <= pend_d;
            req_q       <= req_d;
            cnt_q       <= cnt_d;
            auto_q      <= auto_d;
            force_black <= force_black_d;
            run_en      <= run_en_d;
            busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_display_source_sched.sv
// Bench for display_source_sched: directed scenarios with randomized row
// timing and request noise, checked every cycle against a frame-level model.
module tb_display_source_sched;

    localparam int unsigned V_ACTIVE     = 480;
    localparam int unsigned BLANK_FRAMES = 4;
    localparam int unsigned AUTO_FRAMES  = 3;
    localparam int unsigned AUTO_LAST    = 3;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic [10:0] row = '0;
    logic [2:0]  mode_req = '0;
    logic        auto_en = 1'b0;
    logic [2:0]  sel;
    logic        force_black;
    logic [7:0]  run_en;
    logic        frame_tick;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    // Reference model state (frame-level view of the sequencer).
    bit m_run;
    int m_sel, m_pend, m_left, m_auto, m_req;
    bit m_tick;
    int m_prev_row;

    // Logging used by scenario-level checks.
    bit   log_on = 1'b0;
    bit   tick_busy[$];
    int   sel_log[$];
    int   ft_count = 0;

    display_source_sched #(
        .V_ACTIVE    (V_ACTIVE),
        .BLANK_FRAMES(BLANK_FRAMES),
        .AUTO_FRAMES (AUTO_FRAMES),
        .AUTO_LAST   (AUTO_LAST)
    ) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .row        (row),
        .mode_req   (mode_req),
        .auto_en    (auto_en),
        .sel        (sel),
        .force_black(force_black),
        .run_en     (run_en),
        .frame_tick (frame_tick),
        .busy       (busy)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply the rules for one rising edge, using the inputs present at that edge.
    task automatic model_edge();
        int mr;
        int nxt;
        bit go;
        mr = int'(mode_req);
        if (!rst_b) begin
            m_run = 0; m_sel = 0; m_pend = 0; m_left = BLANK_FRAMES;
            m_auto = 0; m_req = 0; m_tick = 0; m_prev_row = 0;
            return;
        end
        if (m_tick) begin
            if (m_run) begin
                go  = 0;
                nxt = 0;
                if (!auto_en) begin
                    if (mr == m_req && mr != m_sel) begin
                        go = 1; nxt = mr;
                    end
                end else if (m_auto == int'(AUTO_FRAMES) - 1) begin
                    go  = 1;
                    nxt = (m_sel >= int'(AUTO_LAST)) ? 0 : m_sel + 1;
                end else begin
                    m_auto++;
                end
                if (go) begin
                    m_run = 0; m_pend = nxt; m_left = BLANK_FRAMES;
                end
            end else begin
                if (!auto_en && mr == m_req && mr != m_pend) begin
                    m_pend = mr; m_left = BLANK_FRAMES;
                end else if (m_left == 1) begin
                    m_run = 1; m_sel = m_pend; m_auto = 0;
                end else begin
                    m_left--;
                end
            end
            m_req = mr;
        end
        if (!auto_en) m_auto = 0;
        m_tick     = (int'(row) == int'(V_ACTIVE)) && (m_prev_row != int'(V_ACTIVE));
        m_prev_row = int'(row);
    endtask

    // One clock: drive inputs, update the model at the edge, compare at the falling edge.
    task automatic step(input int r, input int m, input bit a, input bit rb);
        row      = 11'(r);
        mode_req = 3'(m);
        auto_en  = a;
        rst_b    = rb;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("sel", 32'(sel), 32'(m_sel));
        chk("force_black", 32'(force_black), 32'(!m_run));
        chk("run_en", 32'(run_en), m_run ? (32'd1 << m_sel) : 32'd0);
        chk("frame_tick", 32'(frame_tick), 32'(m_tick));
        chk("busy", 32'(busy), 32'(!m_run));
        if (frame_tick) ft_count++;
        if (log_on) begin
            if (frame_tick) tick_busy.push_back(busy);
            if (!busy && (sel_log.size() == 0 || sel_log[$] != int'(sel)))
                sel_log.push_back(int'(sel));
        end
    endtask

    task automatic full_frame(input int m, input bit a);
        for (int r = 0; r < 525; r++) step(r, m, a, 1'b1);
    endtask

    // Short frame with random row timing; noisy=1 jitters mode_req away from the boundary.
    task automatic frame(input int m, input bit a, input bit noisy);
        int nlo, nmid, nhi;
        nlo  = int'($urandom_range(2, 5));
        nmid = int'($urandom_range(1, 3));
        nhi  = int'($urandom_range(1, 3));
        for (int i = 0; i < nlo; i++)
            step(int'($urandom_range(0, 479)), noisy ? int'($urandom_range(0, 7)) : m, a, 1'b1);
        for (int i = 0; i < nmid; i++) step(int'(V_ACTIVE), m, a, 1'b1);
        for (int i = 0; i < nhi; i++) step(int'($urandom_range(481, 524)), m, a, 1'b1);
    endtask

    initial begin
        int ones;
        int runs[$];
        int len;
        bit cur;
        int exp_seq[6];
        int ft_before;

        exp_seq = '{3, 0, 1, 2, 3, 0};

        // Reset state
        for (int i = 0; i < 3; i++) step(0, 0, 1'b0, 1'b0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_force_black", 32'(force_black), 32'd1);
        chk("rst_run_en", 32'(run_en), 32'd0);
        chk("rst_frame_tick", 32'(frame_tick), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);

        // Reset exit: four black frames then source 0
        log_on = 1'b1;
        tick_busy.delete();
        for (int f = 0; f < 6; f++) full_frame(0, 1'b0);
        log_on = 1'b0;
        ones = 0;
        foreach (tick_busy[i]) if (tick_busy[i]) ones++;
        chk("t1_tick_count", 32'(tick_busy.size()), 32'd6);
        chk("t1_black_ticks", 32'(ones), 32'd4);
        chk("t1_sel", 32'(sel), 32'd0);
        chk("t1_run_en", 32'(run_en), 32'h01);
        chk("t1_busy", 32'(busy), 32'd0);

        // Manual change 0 -> 3
        frame(3, 1'b0, 1'b0);
        chk("t2_first_tick_run_en", 32'(run_en), 32'h01);
        frame(3, 1'b0, 1'b0);
        chk("t2_enter_blank_run_en", 32'(run_en), 32'h00);
        chk("t2_enter_blank_sel", 32'(sel), 32'd0);
        for (int f = 0; f < 3; f++) begin
            frame(3, 1'b0, 1'b0);
            chk("t2_blank_sel", 32'(sel), 32'd0);
        end
        frame(3, 1'b0, 1'b0);
        chk("t2_sel", 32'(sel), 32'd3);
        chk("t2_run_en", 32'(run_en), 32'h08);

        // Request noise between ticks must not disturb the running source
        for (int f = 0; f < 4; f++) begin
            frame(3, 1'b0, 1'b1);
            chk("t3_run_en", 32'(run_en), 32'h08);
        end

        // Attract mode: 3 run ticks, 4 blank ticks, sources wrap at AUTO_LAST
        log_on = 1'b1;
        tick_busy.delete();
        sel_log.delete();
        for (int f = 0; f < 38; f++) frame(int'($urandom_range(0, 7)), 1'b1, 1'b0);
        log_on = 1'b0;
        chk("t4_first_tick_run", 32'(tick_busy.size() > 0 ? tick_busy[0] : 1'b1), 32'd0);
        cur = (tick_busy.size() > 0) ? tick_busy[0] : 1'b0;
        len = 0;
        foreach (tick_busy[i]) begin
            if (tick_busy[i] == cur) len++;
            else begin
                runs.push_back(len);
                len = 1;
                cur = tick_busy[i];
            end
        end
        chk("t4_stints", 32'(runs.size()), 32'd10);
        foreach (runs[i]) chk((i % 2 == 0) ? "t4_run_len" : "t4_blank_len",
                              32'(runs[i]), (i % 2 == 0) ? 32'd3 : 32'd4);
        chk("t4_seq_len", 32'(sel_log.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            if (i < sel_log.size()) chk("t4_seq", 32'(sel_log[i]), 32'(exp_seq[i]));

        // Dropping auto_en mid-blank still lands on the pending source (1)
        for (int f = 0; f < 4; f++) frame(1, 1'b0, 1'b0);
        chk("t4b_sel", 32'(sel), 32'd1);
        chk("t4b_run_en", 32'(run_en), 32'h02);

        // Retarget during blank: 1 -> (5 abandoned) -> 2
        frame(5, 1'b0, 1'b0);
        frame(5, 1'b0, 1'b0);
        chk("t5_blank_run_en", 32'(run_en), 32'h00);
        for (int f = 0; f < 5; f++) begin
            frame(2, 1'b0, 1'b0);
            chk("t5_hold_sel", 32'(sel), 32'd1);
        end
        frame(2, 1'b0, 1'b0);
        chk("t5_sel", 32'(sel), 32'd2);
        chk("t5_run_en", 32'(run_en), 32'h04);

        // Source 7 passes through; attract from above AUTO_LAST wraps to 0
        for (int f = 0; f < 6; f++) frame(7, 1'b0, 1'b0);
        chk("t7_sel", 32'(sel), 32'd7);
        chk("t7_run_en", 32'(run_en), 32'h80);
        for (int f = 0; f < 7; f++) frame(7, 1'b1, 1'b0);
        chk("t7_auto_sel", 32'(sel), 32'd0);
        chk("t7_auto_run_en", 32'(run_en), 32'h01);

        // Random requests and attract toggling
        for (int c = 0; c < 15; c++) begin
            int m, n;
            bit a;
            m = int'($urandom_range(0, 7));
            a = ($urandom_range(0, 3) == 0);
            n = int'($urandom_range(1, 6));
            for (int f = 0; f < n; f++) frame(m, a, ($urandom_range(0, 1) == 1));
        end

        // Reach blank with sel=3, then reset there
        for (int f = 0; f < 8; f++) frame(3, 1'b0, 1'b0);
        chk("t6_sel3", 32'(sel), 32'd3);
        frame(6, 1'b0, 1'b0);
        frame(6, 1'b0, 1'b0);
        chk("t6_blank_busy", 32'(busy), 32'd1);
        chk("t6_blank_sel", 32'(sel), 32'd3);
        step(int'(V_ACTIVE), 6, 1'b0, 1'b0);
        chk("t6_rst_sel", 32'(sel), 32'd0);
        chk("t6_rst_force_black", 32'(force_black), 32'd1);
        chk("t6_rst_frame_tick", 32'(frame_tick), 32'd0);
        ft_before = ft_count;
        for (int i = 0; i < 10; i++) step(int'(V_ACTIVE), 6, 1'b0, 1'b1);
        chk("t6_single_tick", 32'(ft_count - ft_before), 32'd1);
        for (int i = 0; i < 3; i++) step(100 + i, 6, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/display_source_sched.md
Name: display_source_sched

Overview:
- Sequences which video source drives the VGA colour mux: test bars, game of life, snake, tetris, or a flat grey level.
- Replaces direct switch-to-mux wiring.
- A new source is committed only at a frame boundary, after the request has been stable for two frames, with a programmable number of black frames in between.
- Provides an attract mode that cycles through the game sources automatically, and gates a per-source run enable so that inactive games freeze.

Parameters:
- V_ACTIVE, 480, number of visible rows; a frame boundary is the row counter entering row V_ACTIVE.
- BLANK_FRAMES, 4, black frames inserted on every source change (1..15).
- AUTO_FRAMES, 600, frames spent in each source during attract mode (1..4095).
- AUTO_LAST, 3, highest source index visited in attract mode (sources 0..AUTO_LAST).

Ports:
- clk, input, 1, 50 MHz system clock.
- rst_b, input, 1, synchronous active-low reset.
- row, input, 11, current VGA row from the VGA timing block.
- mode_req, input, 3, requested source index (switches).
- auto_en, input, 1, 1 = attract mode; in this mode mode_req is ignored.
- sel, output, 3, source index to the colour muxes.
- force_black, output, 1, 1 = top level drives RGB to zero.
- run_en, output, 8, one-hot run enable; bit sel is set only in RUN.
- frame_tick, output, 1, one-cycle pulse at every frame boundary.
- busy, output, 1, high whenever the state is not RUN.

Behaviour:
- Everything is registered on the rising edge of clk. When rst_b=0 on an edge, every register takes its reset value.

Reset values:
- state = BLANK, sel = 0, force_black = 1, run_en = 0, frame_tick = 0, busy = 1.
- Blank counter = BLANK_FRAMES, auto counter = 0, pend = 0, req_q = 0.

Frame boundary detection:
- row_q is the registered row.
- bnd = (row == V_ACTIVE) && (row_q != V_ACTIVE).
- frame_tick is registered bnd, so it pulses 1 cycle after row first equals V_ACTIVE.
- Frame-boundary actions below are evaluated in the cycle where frame_tick = 1.
- A row that holds at V_ACTIVE produces only one tick.

Request filter (manual mode):
- At each tick, req_q <= mode_req.
- A change is accepted at a tick when mode_req == req_q (stable across two ticks) and mode_req != sel.
- Values changing between ticks are ignored.

State RUN:
- force_black = 0, run_en = one-hot(sel), busy = 0.
- At a tick, if a change is accepted (manual) or the auto counter reaches AUTO_FRAMES-1 (auto):
  - load pend (manual: mode_req; auto: sel==AUTO_LAST ? 0 : sel+1);
  - go to BLANK with counter = BLANK_FRAMES.
- In the same cycle: force_black = 1, run_en = 0, busy = 1. sel is unchanged.

State BLANK:
- force_black = 1, run_en = 0.
- The counter decrements at each tick.
- At the tick where the counter is 1:
  - sel <= pend;
  - go to RUN on the next cycle;
  - auto counter cleared.
- Reset exit: pend = 0, so sel = 0 after BLANK_FRAMES ticks.

Auto counter:
- Counts ticks only in RUN with auto_en = 1. Width is 12 bits.
- Cleared on every entry to RUN.
- Cleared while auto_en = 0.

Attract mode edge cases:
- If auto_en rises while in RUN with sel > AUTO_LAST, the next auto advance goes to 0.
- Clearing auto_en during BLANK does not cancel the change in progress.

Manual change during BLANK:
- A stable request for a different source, arriving in BLANK, updates pend and restarts the counter at BLANK_FRAMES.
- A request equal to pend is ignored.

Other edge cases:
- Manual request equal to sel: no transition, run_en undisturbed.
- mode_req values 4..7 are legal; sel passes them through.

Test Plan:
1. Reset, then feed a row counter wrapping 0..524 with mode_req = 0 and auto_en = 0:
   - force_black = 1 for 4 frame_ticks;
   - then sel = 0, run_en = 8'h01, busy = 0.
2. In RUN, set mode_req = 3 held for 2 ticks:
   - the second tick enters BLANK (run_en = 0);
   - sel stays 0 for 3 more ticks, then sel = 3, run_en = 8'h08.
3. In RUN, toggle mode_req 0→2→0 within one frame:
   - no transition, run_en is never deasserted.
4. With AUTO_FRAMES overridden to 3, set auto_en = 1:
   - sel steps 0,1,2,3,0;
   - each RUN lasts exactly 3 ticks, separated by 4 blank ticks.
5. Change to source 1, then 2 ticks into BLANK hold mode_req = 2 stable:
   - counter restarts;
   - sel goes directly to 2 after 4 further ticks and never shows 1.
6. Assert rst_b = 0 during BLANK with sel = 3:
   - next cycle sel = 0, force_black = 1, frame_tick = 0;
   - also hold row at 480 for several cycles and check only one frame_tick is produced.
